// File: rtl/stack_alu_core_if.sv
// Decoder-facing bundle for stack_alu_core: operation/immediate inputs and
// the combinational stack and ALU views returned to the datapath.
interface stack_alu_core_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH + 1)
);
  logic [2:0]       stackOP;
  logic [2:0]       aluOP;
  logic             src_sel;
  logic [WIDTH-1:0] immediate;
  logic [WIDTH-1:0] aOut;
  logic [WIDTH-1:0] bOut;
  logic [WIDTH-1:0] ALU_out;
  logic             Overflow;
  logic [CW-1:0]    count;
  logic             full;
  logic             empty;
  logic             fault;

  modport master (
    output stackOP, aluOP, src_sel, immediate,
    input  aOut, bOut, ALU_out, Overflow, count, full, empty, fault
  );

  modport slave (
    input  stackOP, aluOP, src_sel, immediate,
    output aOut, bOut, ALU_out, Overflow, count, full, empty, fault
  );
endinterface

// File: rtl/stack_alu_core.sv
// Register stack with occupancy tracking, combinational ALU over TOS/NOS,
// and a sticky fault flag raised by any operation whose precondition fails.
module stack_alu_core #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input logic             CLK,
  input logic             reset,
  stack_alu_core_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  localparam logic [2:0] OP_NOP     = 3'b000;
  localparam logic [2:0] OP_PUSH    = 3'b001;
  localparam logic [2:0] OP_POP     = 3'b010;
  localparam logic [2:0] OP_BINOP   = 3'b011;
  localparam logic [2:0] OP_DUP     = 3'b100;
  localparam logic [2:0] OP_SWAP    = 3'b101;
  localparam logic [2:0] OP_REPLACE = 3'b110;
  localparam logic [2:0] OP_CLEAR   = 3'b111;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0]    cnt;
  logic             fault_q;

  logic [AW-1:0]    push_idx;
  logic [AW-1:0]    tos_idx;
  logic [AW-1:0]    nos_idx;
  logic             has_one;
  logic             has_two;
  logic             is_full;
  logic [WIDTH-1:0] a_val;
  logic [WIDTH-1:0] b_val;
  logic [WIDTH-1:0] alu_res;
  logic             ovf;
  logic [WIDTH-1:0] wr_val;

  assign push_idx = AW'(cnt);
  assign tos_idx  = AW'(cnt - CW'(1));
  assign nos_idx  = AW'(cnt - CW'(2));
  assign has_one  = cnt >= CW'(1);
  assign has_two  = cnt >= CW'(2);
  assign is_full  = cnt == CW'(DEPTH);

  // Entries above the occupancy line are stale after CLEAR, so mask them.
  assign a_val  = has_one ? mem[tos_idx] : '0;
  assign b_val  = has_two ? mem[nos_idx] : '0;
  assign wr_val = bus.src_sel ? bus.immediate : alu_res;

  always_comb begin
    alu_res = '0;
    ovf     = 1'b0;
    case (bus.aluOP)
      3'b000: begin
        alu_res = b_val + a_val;
        ovf = (b_val[WIDTH-1] == a_val[WIDTH-1]) && (alu_res[WIDTH-1] != a_val[WIDTH-1]);
      end
      3'b001: begin
        alu_res = b_val - a_val;
        ovf = (b_val[WIDTH-1] != a_val[WIDTH-1]) && (alu_res[WIDTH-1] != b_val[WIDTH-1]);
      end
      3'b010:  alu_res = b_val & a_val;
      3'b011:  alu_res = b_val | a_val;
      3'b100:  alu_res = b_val ^ a_val;
      3'b101:  alu_res = b_val << a_val[3:0];
      3'b110:  alu_res = b_val >> a_val[3:0];
      default: alu_res = a_val;
    endcase
  end

  // Illegal ops leave mem/cnt untouched and only latch the fault.
  always_ff @(posedge CLK) begin
    if (reset) begin
      cnt     <= '0;
      fault_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      case (bus.stackOP)
        OP_NOP: ;
        OP_PUSH:
          if (!is_full) begin
            mem[push_idx] <= wr_val;
            cnt <= cnt + CW'(1);
          end else fault_q <= 1'b1;
        OP_POP:
          if (has_one) cnt <= cnt - CW'(1);
          else fault_q <= 1'b1;
        OP_BINOP:
          if (has_two) begin
            mem[nos_idx] <= alu_res;
            cnt <= cnt - CW'(1);
          end else fault_q <= 1'b1;
        OP_DUP:
          if (has_one && !is_full) begin
            mem[push_idx] <= a_val;
            cnt <= cnt + CW'(1);
          end else fault_q <= 1'b1;
        OP_SWAP:
          if (has_two) begin
            mem[tos_idx] <= b_val;
            mem[nos_idx] <= a_val;
          end else fault_q <= 1'b1;
        OP_REPLACE:
          if (has_one) mem[tos_idx] <= wr_val;
          else fault_q <= 1'b1;
        OP_CLEAR: cnt <= '0;
        default: ;
      endcase
    end
  end

  assign bus.aOut     = a_val;
  assign bus.bOut     = b_val;
  assign bus.ALU_out  = alu_res;
  assign bus.Overflow = ovf;
  assign bus.count    = cnt;
  assign bus.full     = is_full;
  assign bus.empty    = cnt == '0;
  assign bus.fault    = fault_q;
endmodule

// File: tb/tb_stack_alu_core.sv
// Directed bench for stack_alu_core at WIDTH=16, DEPTH=4 with hand-computed
// expectations checked by immediate assertions.
module tb_stack_alu_core;
  localparam int WIDTH = 16;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  localparam logic [2:0] NOP = 3'b000, PUSH = 3'b001, POP = 3'b010, BINOP = 3'b011;
  localparam logic [2:0] DUP = 3'b100, SWAP = 3'b101, REPL = 3'b110, CLEAR = 3'b111;
  localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, AND_ = 3'b010, OR_ = 3'b011;
  localparam logic [2:0] XOR_ = 3'b100, SLL = 3'b101, SRL = 3'b110, PASS = 3'b111;

  logic CLK;
  logic reset;
  int   passed;
  int   total;
  int   failed;

  stack_alu_core_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CW(CW)) bus ();

  stack_alu_core #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CW(CW)) dut (
    .CLK   (CLK),
    .reset (reset),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one operation for a single cycle, then return to NOP just after the edge.
  task automatic applyStimulus(input logic [2:0] op, input logic [2:0] alu,
                               input logic sel, input logic [15:0] imm);
    bus.stackOP   = op;
    bus.aluOP     = alu;
    bus.src_sel   = sel;
    bus.immediate = imm;
    @(posedge CLK);
    #1;
    bus.stackOP = NOP;
  endtask

  task automatic pushImm(input logic [15:0] imm);
    applyStimulus(PUSH, ADD, 1'b1, imm);
  endtask

  task automatic doReset();
    reset = 1'b1;
    applyStimulus(NOP, ADD, 1'b0, 16'h0);
    reset = 1'b0;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    failed = 0;
    reset  = 1'b1;
    bus.stackOP   = NOP;
    bus.aluOP     = ADD;
    bus.src_sel   = 1'b0;
    bus.immediate = 16'h0;
    @(posedge CLK);
    #1;
    doReset();

    check("reset_count", 32'(bus.count), 0);
    check("reset_aOut", 32'(bus.aOut), 0);
    check("reset_bOut", 32'(bus.bOut), 0);
    check("reset_alu", 32'(bus.ALU_out), 0);
    check("reset_ovf", 32'(bus.Overflow), 0);
    check("reset_empty", 32'(bus.empty), 1);
    check("reset_full", 32'(bus.full), 0);
    check("reset_fault", 32'(bus.fault), 0);

    pushImm(16'd5);
    pushImm(16'd3);
    check("push2_aOut", 32'(bus.aOut), 3);
    check("push2_bOut", 32'(bus.bOut), 5);
    check("push2_count", 32'(bus.count), 2);
    applyStimulus(BINOP, SUB, 1'b0, 16'h0);
    check("sub_aOut", 32'(bus.aOut), 2);
    check("sub_bOut", 32'(bus.bOut), 0);
    check("sub_count", 32'(bus.count), 1);
    check("sub_fault", 32'(bus.fault), 0);

    doReset();
    pushImm(16'd1);
    pushImm(16'd2);
    pushImm(16'd3);
    pushImm(16'd4);
    check("full_flag", 32'(bus.full), 1);
    pushImm(16'd9);
    check("ovpush_count", 32'(bus.count), 4);
    check("ovpush_aOut", 32'(bus.aOut), 4);
    check("ovpush_fault", 32'(bus.fault), 1);
    applyStimulus(CLEAR, ADD, 1'b0, 16'h0);
    check("clear_count", 32'(bus.count), 0);
    check("clear_aOut", 32'(bus.aOut), 0);
    check("clear_empty", 32'(bus.empty), 1);
    check("clear_fault", 32'(bus.fault), 1);
    doReset();
    check("reset_clr_fault", 32'(bus.fault), 0);

    applyStimulus(POP, ADD, 1'b0, 16'h0);
    check("pop_empty_fault", 32'(bus.fault), 1);
    check("pop_empty_count", 32'(bus.count), 0);
    check("pop_empty_aOut", 32'(bus.aOut), 0);
    doReset();
    pushImm(16'd7);
    applyStimulus(BINOP, ADD, 1'b0, 16'h0);
    check("binop1_fault", 32'(bus.fault), 1);
    check("binop1_aOut", 32'(bus.aOut), 7);
    check("binop1_count", 32'(bus.count), 1);
    applyStimulus(SWAP, ADD, 1'b0, 16'h0);
    check("swap1_aOut", 32'(bus.aOut), 7);

    doReset();
    pushImm(16'h7FFF);
    pushImm(16'h0001);
    bus.aluOP = ADD;
    #1;
    check("add_ovf_alu", 32'(bus.ALU_out), 'h8000);
    check("add_ovf_flag", 32'(bus.Overflow), 1);
    applyStimulus(BINOP, ADD, 1'b0, 16'h0);
    check("add_commit_aOut", 32'(bus.aOut), 'h8000);
    check("add_commit_count", 32'(bus.count), 1);
    pushImm(16'h0001);
    bus.aluOP = SUB;
    #1;
    check("sub_ovf_alu", 32'(bus.ALU_out), 'h7FFF);
    check("sub_ovf_flag", 32'(bus.Overflow), 1);
    bus.aluOP = XOR_;
    #1;
    check("xor_alu", 32'(bus.ALU_out), 'h8001);
    check("xor_ovf", 32'(bus.Overflow), 0);

    doReset();
    pushImm(16'h00F0);
    pushImm(16'h0004);
    bus.aluOP = SLL;
    #1;
    check("sll_alu", 32'(bus.ALU_out), 'h0F00);
    bus.aluOP = SRL;
    #1;
    check("srl_alu", 32'(bus.ALU_out), 'h000F);
    bus.aluOP = OR_;
    #1;
    check("or_alu", 32'(bus.ALU_out), 'h00F4);
    bus.aluOP = AND_;
    #1;
    check("and_alu", 32'(bus.ALU_out), 'h0000);
    bus.aluOP = SUB;
    #1;
    check("sub_noovf", 32'(bus.Overflow), 0);

    doReset();
    pushImm(16'h000A);
    pushImm(16'h000B);
    applyStimulus(SWAP, ADD, 1'b0, 16'h0);
    check("swap_aOut", 32'(bus.aOut), 'hA);
    check("swap_bOut", 32'(bus.bOut), 'hB);
    applyStimulus(DUP, ADD, 1'b0, 16'h0);
    check("dup_aOut", 32'(bus.aOut), 'hA);
    check("dup_bOut", 32'(bus.bOut), 'hA);
    check("dup_count", 32'(bus.count), 3);
    applyStimulus(REPL, ADD, 1'b1, 16'h0055);
    check("repl_aOut", 32'(bus.aOut), 'h55);
    check("repl_bOut", 32'(bus.bOut), 'hA);
    check("repl_count", 32'(bus.count), 3);
    check("repl_fault", 32'(bus.fault), 0);
    applyStimulus(PUSH, PASS, 1'b0, 16'h0);
    check("pushalu_aOut", 32'(bus.aOut), 'h55);
    check("pushalu_bOut", 32'(bus.bOut), 'h55);
    check("pushalu_full", 32'(bus.full), 1);
    applyStimulus(DUP, ADD, 1'b0, 16'h0);
    check("dupfull_fault", 32'(bus.fault), 1);
    check("dupfull_count", 32'(bus.count), 4);
    applyStimulus(POP, ADD, 1'b0, 16'h0);
    check("popfull_count", 32'(bus.count), 3);
    check("popfull_bOut", 32'(bus.bOut), 'hA);

    doReset();
    pushImm(16'h0011);
    pushImm(16'h0022);
    pushImm(16'h0033);
    check("pre_rst_count", 32'(bus.count), 3);
    reset = 1'b1;
    applyStimulus(PUSH, ADD, 1'b1, 16'h1234);
    reset = 1'b0;
    check("rst_op_count", 32'(bus.count), 0);
    check("rst_op_aOut", 32'(bus.aOut), 0);
    check("rst_op_empty", 32'(bus.empty), 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/stack_alu_core.md
# stack_alu_core

Parametrised successor to the 16-bit push/pop stack datapath. It combines a register stack of configurable width and depth with a combinational ALU and a write-source select. It adds occupancy tracking, full/empty flags, DUP/SWAP/REPLACE/CLEAR stack operations, and a sticky fault flag for illegal operations. It sits between the instruction decoder, which drives `stackOP`, `aluOP`, `immediate` and `src_sel`, and the rest of the stack processor datapath.

## Interface
Parameters:
- `WIDTH`, 16: data width in bits (≥ 4).
- `DEPTH`, 8: number of stack entries (≥ 2).
- `CW`, `$clog2(DEPTH+1)`: width of the occupancy count.

Ports:
- `CLK`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high; has priority over all operations.
- `stackOP`  in  3  stack operation (encoding below).
- `aluOP`  in  3  ALU operation (encoding below).
- `src_sel`  in  1  write source `w`: 0 = `ALU_out`, 1 = `immediate`.
- `immediate`  in  WIDTH  immediate operand.
- `aOut`  out  WIDTH  top of stack (TOS); 0 when `count` < 1.
- `bOut`  out  WIDTH  next on stack (NOS); 0 when `count` < 2.
- `ALU_out`  out  WIDTH  combinational result of `aluOP` applied to `aOut`/`bOut`.
- `Overflow`  out  1  signed overflow of ADD/SUB; 0 for all other ops.
- `count`  out  CW  current occupancy, 0..DEPTH.
- `full`  out  1  `count` == DEPTH.
- `empty`  out  1  `count` == 0.
- `fault`  out  1  sticky illegal-operation flag.

## Operation
- Storage: DEPTH×WIDTH register array plus `count`. TOS is entry `count-1`.
- stackOP encoding:
  - 000 NOP
  - 001 PUSH `w`: requires not full; `count`+1.
  - 010 POP: requires `count` ≥ 1; `count`−1.
  - 011 BINOP: requires `count` ≥ 2; pops TOS and NOS, pushes `ALU_out`; `count`−1. `src_sel` is ignored.
  - 100 DUP: requires `count` ≥ 1 and not full; pushes `aOut`.
  - 101 SWAP: requires `count` ≥ 2; exchanges TOS and NOS.
  - 110 REPLACE: requires `count` ≥ 1; TOS ← `w`; `count` unchanged.
  - 111 CLEAR: `count` ← 0. Entries are not required to be zeroed, but `aOut`/`bOut` read 0. Never faults.
- Illegal operation: any unmet requirement above.
  - Stack contents and `count` are left unchanged (the op behaves as NOP).
  - `fault` is set to 1 on that edge and stays 1 until `reset`. CLEAR does not clear it.
- aluOP encoding. A = `aOut`, B = `bOut`; results are truncated to WIDTH.
  - 000 ADD: B+A
  - 001 SUB: B−A
  - 010 AND
  - 011 OR
  - 100 XOR
  - 101 SLL: B << A[3:0]
  - 110 SRL: B >> A[3:0] (logical)
  - 111 PASS: A
- `Overflow` for ADD: operands have the same sign and the result sign differs.
- `Overflow` for SUB: B and A have different signs and the result sign differs from B.
- Reset: `count` = 0 and all entries = 0. Therefore `aOut` = `bOut` = 0, `ALU_out` = 0 (with `aluOP` = ADD), `Overflow` = 0, `empty` = 1, `full` = 0, `fault` = 0.

## Timing
- Outputs `aOut`, `bOut`, `ALU_out`, `Overflow`, `full` and `empty` are combinational from registered state and inputs. There is no output register.
- Every stack operation commits in one cycle. Results are visible on the outputs right after the edge. Back-to-back operations are allowed every cycle with no stall.
- The BINOP push value is the `ALU_out` present before the edge, i.e. computed on the pre-op TOS/NOS.
- PUSH with `src_sel`=0 pushes the pre-edge `ALU_out`; the stack does not pop.
- `fault` rises on the same edge as the illegal operation.
- `reset` asserted in the same cycle as any stackOP: the reset state wins and the op is discarded.
- At `count` == DEPTH, POP/BINOP/SWAP/REPLACE remain legal.
- At `count` == 1, BINOP and SWAP fault.

## Test plan
- Basic push and subtract (WIDTH=16, DEPTH=4):
  - Reset, then PUSH imm 5, then PUSH imm 3 → `aOut`=3, `bOut`=5, `count`=2.
  - BINOP with SUB → `aOut`=2, `bOut`=0, `count`=1, `fault`=0.
- Full-stack fault: push 1, 2, 3, 4 → `full`=1. PUSH 9 → `count`=4, `aOut`=4, `fault`=1.
  - CLEAR → `count`=0, `fault` still 1.
  - `reset` → `fault`=0.
- Empty-stack fault: from reset, POP → `fault`=1, `count`=0, `aOut`=0.
  - Separately: PUSH 7, then BINOP → `fault`=1, `aOut`=7, `count`=1.
- Signed overflow: push 0x7FFF, push 0x0001, `aluOP`=ADD → `ALU_out`=0x8000, `Overflow`=1 before the edge.
  - BINOP commits `aOut`=0x8000.
  - With `aluOP`=SUB on stack {0x8000, 0x0001} → `ALU_out`=0x7FFF, `Overflow`=1.
- DUP/SWAP/REPLACE: stack {…, 0xA, 0xB} (0xB on top).
  - SWAP → `aOut`=0xA, `bOut`=0xB.
  - DUP → `aOut`=0xA, `bOut`=0xA, `count`+1.
  - REPLACE imm 0x55 → `aOut`=0x55, `count` unchanged.
- Reset mid-operation: assert `reset` together with PUSH imm 0x1234 at `count`=3 → next cycle `count`=0, `aOut`=0, `empty`=1.
